// File: rtl/alu_divider_pkg.sv
// Shared ALU definitions: divider width, divider FSM encoding, ALU control opcodes.
// Pure declarations, no logic; imported by the divider files.
// Backpressure: not applicable.
package alu_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // ALU control encodings as decoded by the control unit; DIV/DIVU route to the divider.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_MUL  = 4'd9,
        ALU_DIV  = 4'd10,
        ALU_DIVU = 4'd11
    } alu_ctrl_e;

    function automatic logic is_div_op(input alu_ctrl_e op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/alu_divider_if.sv
// Request/result bundle between the control unit and the iterative divider.
// master drives the request, slave (the divider) returns status and results.
// Backpressure: start is only honoured while busy is low.
interface alu_divider_if #(
    parameter int WIDTH = alu_pkg::DIV_WIDTH
) ();

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, quotient, remainder, div_zero
    );

endinterface

// File: rtl/alu_divider_div_step.sv
// One restoring division step on unsigned magnitudes: shift in next dividend bit, trial subtract.
// Combinational, zero latency.
// Backpressure: none.
module div_step #(
    parameter int WIDTH = alu_pkg::DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] q_o
);

    // Shifted remainder keeps its carry-out bit: with divisors above 2^(WIDTH-1)
    // the partial remainder can briefly need WIDTH+1 bits.
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    assign rem_sh = {rem_i, q_i[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, divisor_i};

    // Keep the difference and set the quotient bit when the subtract does not borrow.
    always_comb begin
        rem_o = rem_sh[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_o = trial[WIDTH-1:0];
            q_o[0] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Latency: WIDTH cycles from accepted start to done; divide-by-zero finishes on the accept edge.
// Backpressure: busy high while iterating; start is ignored until busy drops.
module alu_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_divider_if.slave div_if
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] rem_q,   rem_d;     // working partial remainder
    logic [WIDTH-1:0] wq_q,    wq_d;      // working quotient / remaining dividend bits
    logic [WIDTH-1:0] dvs_q,   dvs_d;     // divisor magnitude
    logic             qneg_q,  qneg_d;
    logic             rneg_q,  rneg_d;
    logic [WIDTH-1:0] quo_q,   quo_d;
    logic [WIDTH-1:0] rmd_q,   rmd_d;
    logic             dz_q,    dz_d;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_q;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             accept;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .q_i       (wq_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // Most negative value maps to itself and is then treated as unsigned, which is correct.
    assign a_neg  = div_if.is_signed & div_if.a[WIDTH-1];
    assign b_neg  = div_if.is_signed & div_if.b[WIDTH-1];
    assign a_mag  = a_neg ? -div_if.a : div_if.a;
    assign b_mag  = b_neg ? -div_if.b : div_if.b;
    assign accept = div_if.start && (state_q != ST_RUN);

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            wq_q    <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            wq_q    <= wq_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dz_q    <= dz_d;
        end
    end

    // Next-state: accept requests when not running, iterate, sign-fix on the final step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        wq_d    = wq_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dz_d    = dz_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (div_if.b == '0) begin
                        // No iterations: report all-ones quotient, dividend as remainder.
                        state_d = ST_DONE;
                        quo_d   = '1;
                        rmd_d   = div_if.a;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        rem_d   = '0;
                        wq_d    = a_mag;
                        dvs_d   = b_mag;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        dz_d    = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                rem_d = step_rem;
                wq_d  = step_q;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    quo_d   = qneg_q ? -step_q   : step_q;
                    rmd_d   = rneg_q ? -step_rem : step_rem;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign div_if.busy      = (state_q == ST_RUN);
    assign div_if.done      = (state_q == ST_DONE);
    assign div_if.quotient  = quo_q;
    assign div_if.remainder = rmd_q;
    assign div_if.div_zero  = dz_q;

endmodule

// File: tb/tb_alu_divider.sv
module tb_alu_divider;

    logic clk;
    logic rst_n;

    alu_divider_if #(.WIDTH(32)) dif ();

    alu_divider #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        logic        exp_dz;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: language division operators, with the two architected special cases.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r, output logic dz);
        dz = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Issue one request, scramble operands after acceptance, wait for done, check timing.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] q, output logic [31:0] r, output logic dz);
        int lat;
        int busy_bad;
        @(negedge clk);
        dif.start = 1'b1; dif.a = a; dif.b = b; dif.is_signed = s;
        @(posedge clk); #1;
        dif.start = 1'b0;
        dif.a = $urandom; dif.b = $urandom; dif.is_signed = ~s;
        lat = 0; busy_bad = 0;
        while (!dif.done && lat < 40) begin
            if (!dif.busy) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        if (dif.busy) busy_bad++;
        chk("latency", lat, (b == 32'd0) ? 32'd0 : 32'd32);
        chk("busy_window", busy_bad, 32'd0);
        q = dif.quotient; r = dif.remainder; dz = dif.div_zero;
        @(posedge clk); #1;
        chk("done_pulse", {31'd0, dif.done}, 32'd0);
    endtask

    vec_t vecs[10];

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] q, r, eq, er, ra, rb;
        logic        dz, edz, rs;
        int          lat, done_cnt;

        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
        vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
        vecs[3] = '{32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
        vecs[4] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
        vecs[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0};
        vecs[6] = '{32'hFFFF_FFF0,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF0,  1'b1};
        vecs[7] = '{32'hFFFF_FFFF,  32'h8000_0001,  1'b0, 32'd1,          32'h7FFF_FFFE,  1'b0};
        vecs[8] = '{32'd0,          32'd5,          1'b1, 32'd0,          32'd0,          1'b0};
        vecs[9] = '{32'hFFFF_FFFF,  32'd1,          1'b1, 32'hFFFF_FFFF,  32'd0,          1'b0};

        dif.start = 1'b0; dif.a = '0; dif.b = '0; dif.is_signed = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, dif.busy}, 32'd0);
        chk("rst_done", {31'd0, dif.done}, 32'd0);
        chk("rst_q", dif.quotient, 32'd0);
        chk("rst_r", dif.remainder, 32'd0);
        chk("rst_dz", {31'd0, dif.div_zero}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Directed vectors; vector 4 follows a divide-by-zero and must clear the flag.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, q, r, dz);
            chk($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
            chk($sformatf("vec%0d_r", i), r, vecs[i].exp_r);
            chk($sformatf("vec%0d_dz", i), {31'd0, dz}, {31'd0, vecs[i].exp_dz});
        end

        // Start re-pulsed with new operands while busy: must be ignored.
        @(negedge clk);
        dif.start = 1'b1; dif.a = 32'd100; dif.b = 32'd7; dif.is_signed = 1'b0;
        @(posedge clk); #1;
        dif.start = 1'b0;
        lat = 0;
        while (!dif.done && lat < 40) begin
            if (lat == 5) begin
                dif.start = 1'b1; dif.a = 32'd1; dif.b = 32'd1; dif.is_signed = 1'b1;
            end else begin
                dif.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("ignore_lat", lat, 32'd32);
        chk("ignore_q", dif.quotient, 32'd14);
        chk("ignore_r", dif.remainder, 32'd2);

        // Back-to-back: new start issued in the done cycle.
        dif.start = 1'b1; dif.a = 32'd9; dif.b = 32'd3; dif.is_signed = 1'b0;
        @(posedge clk); #1;
        dif.start = 1'b0;
        chk("b2b_busy", {31'd0, dif.busy}, 32'd1);
        chk("b2b_hold_q", dif.quotient, 32'd14);
        lat = 0;
        while (!dif.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_lat", lat, 32'd32);
        chk("b2b_q", dif.quotient, 32'd3);
        chk("b2b_r", dif.remainder, 32'd0);

        // Reset ten cycles into an operation: immediate clear, no late done.
        @(negedge clk);
        dif.start = 1'b1; dif.a = 32'hFFFF_FFFF; dif.b = 32'd3; dif.is_signed = 1'b0;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, dif.busy}, 32'd0);
        chk("arst_done", {31'd0, dif.done}, 32'd0);
        chk("arst_q", dif.quotient, 32'd0);
        chk("arst_r", dif.remainder, 32'd0);
        chk("arst_dz", {31'd0, dif.div_zero}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        done_cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (dif.done || dif.busy) done_cnt++;
        end
        chk("arst_no_done", done_cnt, 32'd0);

        // Random scoreboard against the reference model, both signedness modes.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 7))
                0:       ra = 32'h8000_0000;
                1:       ra = $urandom_range(0, 255);
                2:       ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = $urandom | 32'h8000_0000;
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            ref_div(ra, rb, rs, eq, er, edz);
            run_op(ra, rb, rs, q, r, dz);
            chk($sformatf("rnd%0d_q a=%h b=%h s=%0d", i, ra, rb, rs), q, eq);
            chk($sformatf("rnd%0d_r", i), r, er);
            chk($sformatf("rnd%0d_dz", i), {31'd0, dz}, {31'd0, edz});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
